// File: rtl/tri_io_port.sv
// tri_io_port: bidirectional pad-side port with a direction FSM
// (RX -> TURN_TX -> TX -> TURN_RX), guaranteed bus-release turnaround
// cycles, a multi-stage input synchronizer, a valid/ready write path on the
// drive side and change detection on the receive side.
//
// Optional feature: define TRI_IO_PORT_CONTENTION_CHECK_EN to build the
// bus-contention monitor behind err/err_clr. Without it err is tied low and
// err_clr is ignored; both ports stay present.

module tri_io_port #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dir_req,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             driving,
    output logic             busy,
    input  logic             err_clr,
    output logic             err,
    inout  wire  [WIDTH-1:0] io_pin
);

    typedef enum logic [1:0] {
        ST_RX      = 2'd0,
        ST_TURN_TX = 2'd1,
        ST_TX      = 2'd2,
        ST_TURN_RX = 2'd3
    } state_t;

    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int SW = $clog2(SYNC_STAGES + 1);
    localparam logic [TW-1:0] TURN_LAST   = TW'(TURN_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_DONE = SW'(SYNC_STAGES);

    // True when any bit of the two words differs.
    function automatic logic bus_differs(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
        return |(a ^ b);
    endfunction

    state_t                            state_r;
    state_t                            state_next_s;
    logic [TW-1:0]                     turn_cnt_r;
    logic                              turn_last_s;
    logic                              driving_r;
    logic                              busy_r;
    logic [WIDTH-1:0]                  out_reg_r;
    logic                              wr_fire_s;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                  sync_out_s;
    logic [SW-1:0]                     settle_r;
    logic [WIDTH-1:0]                  rd_data_r;
    logic                              rd_valid_r;

    assign turn_last_s = (turn_cnt_r == TURN_LAST);
    assign sync_out_s  = sync_r[SYNC_STAGES-1];

    // The bus is only driven while the registered drive flag is set; reset
    // clears that flag asynchronously, so the pad releases without a clock.
    assign io_pin = driving_r ? out_reg_r : {WIDTH{1'bz}};

    // Writes are refused in the cycle dir_req drops, i.e. the TX exit cycle.
    assign wr_ready  = driving_r & dir_req;
    assign wr_fire_s = wr_valid & wr_ready;

    assign driving  = driving_r;
    assign busy     = busy_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

    // Next-state logic; dir_req is ignored while a turnaround is running.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RX: begin
                if (dir_req) state_next_s = ST_TURN_TX;
                else         state_next_s = ST_RX;
            end
            ST_TURN_TX: begin
                if (turn_last_s) state_next_s = ST_TX;
                else             state_next_s = ST_TURN_TX;
            end
            ST_TX: begin
                if (!dir_req) state_next_s = ST_TURN_RX;
                else          state_next_s = ST_TX;
            end
            ST_TURN_RX: begin
                if (turn_last_s) state_next_s = ST_RX;
                else             state_next_s = ST_TURN_RX;
            end
            default: state_next_s = ST_RX;
        endcase
    end

    // State register plus registered drive/busy flags derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_RX;
            driving_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            driving_r <= (state_next_s == ST_TX);
            busy_r    <= (state_next_s == ST_TURN_TX) || (state_next_s == ST_TURN_RX);
        end
    end

    // Turn counter runs 0..TURN_CYCLES-1 inside either turnaround state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turn_cnt_r <= '0;
        end else if ((state_r == ST_TURN_TX) || (state_r == ST_TURN_RX)) begin
            if (turn_last_s) turn_cnt_r <= '0;
            else             turn_cnt_r <= turn_cnt_r + TW'(1);
        end else begin
            turn_cnt_r <= '0;
        end
    end

    // Output data register; keeps its value across direction changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg_r <= '0;
        end else if (wr_fire_s) begin
            out_reg_r <= wr_data;
        end else begin
            out_reg_r <= out_reg_r;
        end
    end

    // Input synchronizer samples the pad every cycle in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], io_pin};
        end else begin
            sync_r <= io_pin;
        end
    end

    // Receive path: flush stale samples after entering RX, then track the bus
    // and pulse rd_valid whenever the captured value changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_r   <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (state_r == ST_RX) begin
            if (settle_r != SETTLE_DONE) begin
                settle_r   <= settle_r + SW'(1);
                rd_valid_r <= 1'b0;
            end else begin
                rd_data_r  <= sync_out_s;
                rd_valid_r <= bus_differs(sync_out_s, rd_data_r);
            end
        end else begin
            settle_r   <= '0;
            rd_valid_r <= 1'b0;
        end
    end

`ifdef TRI_IO_PORT_CONTENTION_CHECK_EN
    localparam int STW = $clog2(SYNC_STAGES + 2);
    localparam logic [STW-1:0] STABLE_MAX = STW'(SYNC_STAGES + 1);

    logic [STW-1:0] stable_r;
    logic           mismatch_s;
    logic           err_r;

    // Compare only once the driven value has had time to come back through
    // the synchronizer.
    always_comb begin
        mismatch_s = 1'b0;
        if (driving_r && (stable_r == STABLE_MAX)) begin
            mismatch_s = bus_differs(sync_out_s, out_reg_r);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Counts cycles since out_reg last changed or TX was entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_r <= '0;
        end else if (!driving_r || wr_fire_s) begin
            stable_r <= '0;
        end else if (stable_r != STABLE_MAX) begin
            stable_r <= stable_r + STW'(1);
        end else begin
            stable_r <= stable_r;
        end
    end

    // Sticky contention flag; a new mismatch wins over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 1'b0;
        end else if (mismatch_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = err_clr;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_tri_io_port.sv
// Self-checking bench for tri_io_port (WIDTH=8, TURN_CYCLES=3, SYNC_STAGES=2).
// The external bus is modelled with per-bit tri-state drivers.

module tb_tri_io_port;

    localparam int W  = 8;
    localparam int TC = 3;
    localparam int SS = 2;
`ifdef TRI_IO_PORT_CONTENTION_CHECK_EN
    localparam logic CONT_EXP = 1'b1;
`else
    localparam logic CONT_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         dir_req;
    logic         wr_valid;
    logic [W-1:0] wr_data;
    logic         wr_ready;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         driving;
    logic         busy;
    logic         err_clr;
    logic         err;
    wire  [W-1:0] io_bus;
    logic [W-1:0] ext_mask;
    logic [W-1:0] ext_val;

    tri_io_port #(.WIDTH(W), .TURN_CYCLES(TC), .SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .reset    (reset),
        .dir_req  (dir_req),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .driving  (driving),
        .busy     (busy),
        .err_clr  (err_clr),
        .err      (err),
        .io_pin   (io_bus)
    );

    for (genvar g = 0; g < W; g++) begin : g_ext
        assign io_bus[g] = ext_mask[g] ? ext_val[g] : 1'bz;
    end

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] rd_q[$];
    logic [W-1:0] wr_q[$];

    typedef struct {
        logic [W-1:0] bus;
        logic         pulse;
    } rx_vec_t;
    rx_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_rd(input string name);
        logic [W-1:0] e;
        if (rd_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected rd_valid actual=%0h required=none", name, rd_data);
        end else begin
            e = rd_q.pop_front();
            check(name, rd_data, e);
        end
    endtask

    // Waits (bounded) for an rd_valid pulse, returns cycles taken.
    task automatic wait_rd(input string name, output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (rd_valid) begin
                lat = i;
                pop_rd(name);
                break;
            end
        end
        if (lat == 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout actual=no_pulse required=pulse", name);
        end
    endtask

    // From RX: request TX, check the turnaround, release the external driver
    // in the last turn cycle, and land in TX.
    task automatic go_tx();
        dir_req = 1'b1;
        for (int i = 0; i < TC; i++) begin
            step();
            check("turn_tx_busy", busy, 1);
            check("turn_tx_driving", driving, 0);
            check("turn_tx_wr_ready", wr_ready, 0);
            if (ext_mask == 8'hFF) check("turn_tx_released", io_bus, ext_val);
            if (i == TC - 1) ext_mask = 8'h00;
        end
        step();
        check("tx_driving", driving, 1);
        check("tx_busy", busy, 0);
        check("tx_wr_ready", wr_ready, 1);
    endtask

    task automatic write(input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        if (wr_ready) wr_q.push_back(d);
        step();
        wr_valid = 1'b0;
        if (wr_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL write_accept actual=not_ready required=ready");
        end else begin
            check("io_after_write", io_bus, wr_q.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        vecs[0] = '{8'h5A, 1'b1};
        vecs[1] = '{8'h5A, 1'b0};
        vecs[2] = '{8'h00, 1'b1};
        vecs[3] = '{8'hFF, 1'b1};
        vecs[4] = '{8'h81, 1'b1};

        reset = 1'b1; dir_req = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
        err_clr = 1'b0; ext_mask = 8'hFF; ext_val = 8'hA5;
        repeat (3) step();
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_driving", driving, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_bus_released", io_bus, 8'hA5);

        // Reset release: A5 reaches rd_data SS+1 edges later, single pulse.
        rd_q.push_back(8'hA5);
        reset = 1'b0;
        step();
        check("settle_e1_rd", rd_data, 0);
        step();
        check("settle_e2_rd", rd_data, 0);
        check("settle_e2_valid", rd_valid, 0);
        step();
        check("settle_e3_valid", rd_valid, 1);
        pop_rd("settle_e3_rd");
        n = 0;
        repeat (5) begin
            step();
            if (rd_valid) n++;
        end
        check("stable_no_pulse", n, 0);

        // Table-driven receive vectors.
        for (int i = 0; i < 5; i++) begin
            ext_val = vecs[i].bus;
            if (vecs[i].pulse) rd_q.push_back(vecs[i].bus);
            n = 0;
            repeat (4) begin
                step();
                if (rd_valid) begin
                    n++;
                    pop_rd("rx_vec_data");
                end
            end
            check("rx_vec_pulses", n, {31'd0, vecs[i].pulse});
            check("rx_vec_final", rd_data, vecs[i].bus);
        end

        // Into TX and write.
        go_tx();
        write(8'h96);
        write(8'h3C);

        // Drop dir_req with a write pending: refused, bus released in 1 cycle.
        dir_req  = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        #1;
        check("exit_wr_ready", wr_ready, 0);
        step();
        wr_valid = 1'b0;
        check("exit_driving", driving, 0);
        check("exit_busy", busy, 1);
        ext_val  = 8'h5A;
        ext_mask = 8'hFF;
        #1;
        check("exit_released", io_bus, 8'h5A);
        check("turn_rx_rd_hold", rd_data, 8'h81);
        rd_q.push_back(8'h5A);
        for (int i = 0; i < TC - 1; i++) begin
            step();
            check("turn_rx_busy", busy, 1);
            check("turn_rx_valid", rd_valid, 0);
            check("turn_rx_rd_hold", rd_data, 8'h81);
        end
        wait_rd("rx_after_turn", lat);
        check("rx_after_turn_lat", lat, SS + 2);

        // dir_req toggled inside TURN_TX: turn still runs TC cycles, then
        // TX is left at once because dir_req is low on entry.
        dir_req = 1'b1;
        step();
        check("tog_c0_busy", busy, 1);
        check("tog_c0_released", io_bus, 8'h5A);
        dir_req = 1'b0;
        step();
        check("tog_c1_busy", busy, 1);
        check("tog_c1_driving", driving, 0);
        dir_req = 1'b1;
        step();
        check("tog_c2_busy", busy, 1);
        check("tog_c2_driving", driving, 0);
        ext_mask = 8'h00;
        dir_req  = 1'b0;
        step();
        check("tog_tx_driving", driving, 1);
        check("tog_tx_busy", busy, 0);
        check("tog_tx_retained", io_bus, 8'h3C);
        step();
        check("tog_turn_rx_driving", driving, 0);
        check("tog_turn_rx_busy", busy, 1);
        ext_val  = 8'h66;
        ext_mask = 8'hFF;
        #1;
        check("tog_released", io_bus, 8'h66);
        rd_q.push_back(8'h66);
        repeat (TC - 1) step();
        wait_rd("tog_rx", lat);
        check("tog_rx_lat", lat, SS + 2);

        // Asynchronous reset while driving FF.
        go_tx();
        write(8'hFF);
        reset = 1'b1;
        #1;
        check("arst_driving", driving, 0);
        check("arst_wr_ready", wr_ready, 0);
        check("arst_busy", busy, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_valid", rd_valid, 0);
        ext_val  = 8'h00;
        ext_mask = 8'hFF;
        #1;
        check("arst_released", io_bus, 8'h00);
        dir_req = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        check("post_rst_rd", rd_data, 0);

        // Contention monitor.
        go_tx();
        write(8'h0F);
        repeat (6) step();
        check("cont_clean_err", err, 0);
        ext_val  = 8'h80;
        ext_mask = 8'h80;
        repeat (4) step();
        check("cont_err_set", err, CONT_EXP);
        ext_mask = 8'h00;
        repeat (5) step();
        check("cont_err_sticky", err, CONT_EXP);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("cont_err_cleared", err, 0);
        step();
        check("cont_err_stays_clear", err, 0);

        check("rd_queue_empty", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
